// File: rtl/lsu_macc.sv
// -----------------------------------------------------------------------------
// lsu_macc -- memory-access stage of the 5-stage RV32I pipeline.
//
// Takes the registered EX/MEM controls, issues aligned byte/half/word loads and
// stores on a req/gnt/rvalid data bus, and stalls the front of the pipeline
// while an access is outstanding. Holds the MEM/WB register. o_wb_data also
// feeds the WB forwarding path back into execute.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   : a misaligned half/word access issues no
//                                     bus request and no stall. o_misalign
//                                     pulses for one cycle and rd is not
//                                     written.
//                         undefined : o_misalign is tied low. The address is
//                                     aligned down to the access size and the
//                                     access proceeds normally.
//
// Ports:
//   clk_sys, rst_sys          clock (rising edge), async active-high reset
//   i_pip_flush               zero the MEM/WB register (ignored while stalled)
//   i_rd_wen, i_rd_addr       destination write enable / index from EX
//   i_mem_wen, i_mem_ren      store / load request (mutually exclusive)
//   i_mem_size                00 byte, 01 half, 1x word
//   i_mem_unsigned            zero-extend loads (LBU/LHU)
//   i_mem_addr, i_mem_wdata   byte address, store data
//   i_result                  ALU result for non-load instructions
//   o_dbus_*                  data bus request side
//   i_dbus_gnt, i_dbus_rvalid request accepted / read data valid
//   i_dbus_rdata              read data
//   o_stall                   hold IF/ID/EX and EX/MEM this cycle
//   o_misalign                misaligned-access pulse
//   o_rd_wen, o_rd_addr,
//   o_wb_data                 registered MEM/WB outputs
// -----------------------------------------------------------------------------
module lsu_macc (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        i_pip_flush,
  input  logic        i_rd_wen,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_mem_wen,
  input  logic        i_mem_ren,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_unsigned,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [31:0] i_result,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [3:0]  o_dbus_be,
  output logic [31:0] o_dbus_wdata,
  input  logic        i_dbus_gnt,
  input  logic        i_dbus_rvalid,
  input  logic [31:0] i_dbus_rdata,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_wb_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RWAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic        is_word, is_half;
  logic        mem_op, misaligned, access;
  logic [1:0]  lane_off;

  assign is_word = i_mem_size[1];              // 10 and 11 are both word
  assign is_half = (i_mem_size == 2'b01);
  assign mem_op  = i_mem_wen | i_mem_ren;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = mem_op & ((is_half & i_mem_addr[0]) |
                                (is_word & (|i_mem_addr[1:0])));
  assign lane_off   = i_mem_addr[1:0];
`else
  // Misaligned accesses are silently aligned down to the access size.
  assign misaligned = 1'b0;
  assign lane_off   = is_word ? 2'b00 :
                      is_half ? {i_mem_addr[1], 1'b0} : i_mem_addr[1:0];
`endif

  assign access = mem_op & ~misaligned;

  // ---------------------------------------------------------------------------
  // Access FSM: next state and stall.
  // ---------------------------------------------------------------------------
  logic store_done;
  assign store_done = i_mem_wen & i_dbus_gnt;  // a granted store needs no reply

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave
    // it unassigned and infer a latch.
    state_d = state_q;
    o_stall = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          o_stall = ~store_done;
          if (i_dbus_gnt) state_d = i_mem_wen ? ST_IDLE : ST_RWAIT;
          else            state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        o_stall = ~store_done;
        if (i_dbus_gnt) state_d = i_mem_wen ? ST_IDLE : ST_RWAIT;
      end
      ST_RWAIT: begin
        o_stall = ~i_dbus_rvalid;
        if (i_dbus_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst_sys) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Bus request side. Request is forced low during reset so a dropped
  // transaction is never re-issued while the stage is being cleared.
  // ---------------------------------------------------------------------------
  assign o_dbus_req  = ~rst_sys & (((state_q == ST_IDLE) & access) |
                                   (state_q == ST_REQ));
  assign o_dbus_we   = i_mem_wen;
  assign o_dbus_addr = {i_mem_addr[31:2], 2'b00};

  always_comb begin
    o_dbus_be    = 4'b1111;
    o_dbus_wdata = i_mem_wdata;
    if (is_half) begin
      o_dbus_be    = 4'b0011 << lane_off;
      o_dbus_wdata = {2{i_mem_wdata[15:0]}};
    end else if (!is_word) begin
      o_dbus_be    = 4'b0001 << lane_off;
      o_dbus_wdata = {4{i_mem_wdata[7:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Load formatting: pick the addressed lane and extend it.
  // ---------------------------------------------------------------------------
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] load_data;

  always_comb begin
    lane8  = i_dbus_rdata[7:0];
    lane16 = lane_off[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
    unique case (lane_off)
      2'd0: lane8 = i_dbus_rdata[7:0];
      2'd1: lane8 = i_dbus_rdata[15:8];
      2'd2: lane8 = i_dbus_rdata[23:16];
      2'd3: lane8 = i_dbus_rdata[31:24];
      default: lane8 = i_dbus_rdata[7:0];
    endcase

    load_data = i_dbus_rdata;
    if (is_half)
      load_data = {{16{~i_mem_unsigned & lane16[15]}}, lane16};
    else if (!is_word)
      load_data = {{24{~i_mem_unsigned & lane8[7]}}, lane8};
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register. Loads only when the stage is not stalled; a flush in that
  // cycle writes zeros, a flush during a stall is dropped.
  // ---------------------------------------------------------------------------
  logic        rd_wen_q, rd_wen_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] wb_data_q, wb_data_d;

  always_comb begin
    rd_wen_d  = rd_wen_q;
    rd_addr_d = rd_addr_q;
    wb_data_d = wb_data_q;
    if (!o_stall) begin
      if (i_pip_flush) begin
        rd_wen_d  = 1'b0;
        rd_addr_d = 5'd0;
        wb_data_d = 32'd0;
      end else begin
        rd_wen_d  = i_rd_wen & ~misaligned;
        rd_addr_d = i_rd_addr;
        wb_data_d = (i_mem_ren & ~misaligned) ? load_data : i_result;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      rd_wen_q  <= 1'b0;
      rd_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      rd_wen_q  <= rd_wen_d;
      rd_addr_q <= rd_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign o_rd_wen  = rd_wen_q;
  assign o_rd_addr = rd_addr_q;
  assign o_wb_data = wb_data_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // One-cycle pulse; a flushed instruction does not report a trap.
  assign misalign_d = misaligned & ~o_stall & ~i_pip_flush;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) misalign_q <= 1'b0;
    else         misalign_q <= misalign_d;
  end

  assign o_misalign = misalign_q;
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_macc.sv
// -----------------------------------------------------------------------------
// Self-checking bench for lsu_macc: a table of single-cycle store / ALU
// vectors, plus hand-written sequences for loads, delayed grants, flush during
// a stall, reset mid-access and the misaligned-access behaviour.
// -----------------------------------------------------------------------------
module tb_lsu_macc;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        i_pip_flush;
  logic        i_rd_wen;
  logic [4:0]  i_rd_addr;
  logic        i_mem_wen, i_mem_ren;
  logic [1:0]  i_mem_size;
  logic        i_mem_unsigned;
  logic [31:0] i_mem_addr, i_mem_wdata, i_result;
  logic        o_dbus_req, o_dbus_we;
  logic [31:0] o_dbus_addr;
  logic [3:0]  o_dbus_be;
  logic [31:0] o_dbus_wdata;
  logic        i_dbus_gnt, i_dbus_rvalid;
  logic [31:0] i_dbus_rdata;
  logic        o_stall, o_misalign;
  logic        o_rd_wen;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_wb_data;

  int n_checks = 0;
  int n_errors = 0;

  lsu_macc dut (
    .clk_sys        (clk_sys),
    .rst_sys        (rst_sys),
    .i_pip_flush    (i_pip_flush),
    .i_rd_wen       (i_rd_wen),
    .i_rd_addr      (i_rd_addr),
    .i_mem_wen      (i_mem_wen),
    .i_mem_ren      (i_mem_ren),
    .i_mem_size     (i_mem_size),
    .i_mem_unsigned (i_mem_unsigned),
    .i_mem_addr     (i_mem_addr),
    .i_mem_wdata    (i_mem_wdata),
    .i_result       (i_result),
    .o_dbus_req     (o_dbus_req),
    .o_dbus_we      (o_dbus_we),
    .o_dbus_addr    (o_dbus_addr),
    .o_dbus_be      (o_dbus_be),
    .o_dbus_wdata   (o_dbus_wdata),
    .i_dbus_gnt     (i_dbus_gnt),
    .i_dbus_rvalid  (i_dbus_rvalid),
    .i_dbus_rdata   (i_dbus_rdata),
    .o_stall        (o_stall),
    .o_misalign     (o_misalign),
    .o_rd_wen       (o_rd_wen),
    .o_rd_addr      (o_rd_addr),
    .o_wb_data      (o_wb_data)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    i_pip_flush    = 1'b0;
    i_rd_wen       = 1'b0;
    i_rd_addr      = 5'd0;
    i_mem_wen      = 1'b0;
    i_mem_ren      = 1'b0;
    i_mem_size     = 2'b10;
    i_mem_unsigned = 1'b0;
    i_mem_addr     = 32'd0;
    i_mem_wdata    = 32'd0;
    i_result       = 32'd0;
    i_dbus_gnt     = 1'b0;
    i_dbus_rvalid  = 1'b0;
    i_dbus_rdata   = 32'd0;
  endtask

  // Table of accesses that finish in one cycle (stores granted at once, ALU
  // pass-through, flush). Stall must stay low for every entry.
  typedef struct {
    string       name;
    logic        wen, ren;
    logic [1:0]  size;
    logic [31:0] addr, wdata, result;
    logic        rd_wen;
    logic [4:0]  rd;
    logic        flush;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_rd_wen;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[10];

  // Runs one load or store with a scripted grant / rvalid timeline, counts
  // request and stall cycles, and checks bus fields and the MEM/WB result.
  task automatic run_mem(input string name, input logic wen, input logic ren,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] result, input logic [31:0] rdata,
                         input logic [4:0] rd, input int gnt_dly,
                         input int rv_dly, input logic flush_wait,
                         input logic stray_rv, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_wb, input int exp_stalls,
                         input int exp_reqs);
    int   stalls = 0;
    int   reqs   = 0;
    int   wait_cnt = 0;
    logic granted = 1'b0;
    logic done    = 1'b0;
    @(negedge clk_sys);
    drive_nop();
    i_mem_wen      = wen;
    i_mem_ren      = ren;
    i_mem_size     = size;
    i_mem_unsigned = uns;
    i_mem_addr     = addr;
    i_mem_wdata    = wdata;
    i_result       = result;
    i_rd_wen       = ren;
    i_rd_addr      = rd;
    i_dbus_rdata   = rdata;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc != 0) @(negedge clk_sys);
      i_dbus_gnt    = !granted && (cyc == gnt_dly);
      i_dbus_rvalid = granted ? (wait_cnt == rv_dly) : stray_rv;
      i_pip_flush   = flush_wait && granted && (wait_cnt < rv_dly);
      #1;
      if (o_dbus_req) reqs++;
      if (o_stall) stalls++;
      if (cyc == 0) begin
        check({name, " req"},  o_dbus_req,  1);
        check({name, " we"},   o_dbus_we,   wen);
        check({name, " addr"}, o_dbus_addr, exp_addr);
        check({name, " be"},   o_dbus_be,   exp_be);
        if (wen) check({name, " wdata"}, o_dbus_wdata, exp_wdata);
      end
      if (!o_stall) done = 1'b1;
      if (granted) wait_cnt++;
      if (i_dbus_gnt) granted = 1'b1;
      @(posedge clk_sys);
    end
    #1;
    check({name, " completed"},    done,      1);
    check({name, " stall cycles"}, stalls,    exp_stalls);
    check({name, " req cycles"},   reqs,      exp_reqs);
    check({name, " rd_wen"},       o_rd_wen,  ren);
    check({name, " rd_addr"},      o_rd_addr, rd);
    check({name, " wb_data"},      o_wb_data, exp_wb);
    drive_nop();
  endtask

  initial begin
    //          name   wen ren size  addr          wdata         result        rdw rd  fl  req addr         be       wdata         erw erd ewb
    vecs[0] = '{"SW",   1, 0, 2'b10, 32'h100,      32'hDEADBEEF, 32'h100,      0, 0,  0,  1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0,  32'h100};
    vecs[1] = '{"SB3",  1, 0, 2'b00, 32'h203,      32'h000000A5, 32'h203,      0, 0,  0,  1, 32'h200, 4'b1000, 32'hA5A5A5A5, 0, 0,  32'h203};
    vecs[2] = '{"SB1",  1, 0, 2'b00, 32'h201,      32'h12345677, 32'h201,      0, 0,  0,  1, 32'h200, 4'b0010, 32'h77777777, 0, 0,  32'h201};
    vecs[3] = '{"SH2",  1, 0, 2'b01, 32'h102,      32'h00001234, 32'h102,      0, 0,  0,  1, 32'h100, 4'b1100, 32'h12341234, 0, 0,  32'h102};
    vecs[4] = '{"SH0",  1, 0, 2'b01, 32'h300,      32'hCAFEBABE, 32'h300,      0, 0,  0,  1, 32'h300, 4'b0011, 32'hBABEBABE, 0, 0,  32'h300};
    vecs[5] = '{"SW11", 1, 0, 2'b11, 32'h40,       32'h0F0F0F0F, 32'h40,       0, 0,  0,  1, 32'h40,  4'b1111, 32'h0F0F0F0F, 0, 0,  32'h40};
    vecs[6] = '{"ADD",  0, 0, 2'b10, 32'h0,        32'h0,        32'h55,       1, 5,  0,  0, 32'h0,   4'b1111, 32'h0,        1, 5,  32'h55};
    vecs[7] = '{"ALU",  0, 0, 2'b10, 32'h0,        32'h0,        32'hFFFFFFFF, 1, 31, 0,  0, 32'h0,   4'b1111, 32'h0,        1, 31, 32'hFFFFFFFF};
    vecs[8] = '{"FLADD",0, 0, 2'b10, 32'h0,        32'h0,        32'h55,       1, 5,  1,  0, 32'h0,   4'b1111, 32'h0,        0, 0,  32'h0};
    vecs[9] = '{"FLSB", 1, 0, 2'b00, 32'h10,       32'h0000003C, 32'h10,       0, 0,  1,  1, 32'h10,  4'b0001, 32'h3C3C3C3C, 0, 0,  32'h0};

    // Reset state.
    drive_nop();
    rst_sys = 1'b1;
    #2;
    check("reset req",      o_dbus_req, 0);
    check("reset stall",    o_stall,    0);
    check("reset rd_wen",   o_rd_wen,   0);
    check("reset rd_addr",  o_rd_addr,  0);
    check("reset wb_data",  o_wb_data,  0);
    check("reset misalign", o_misalign, 0);
    @(negedge clk_sys);
    rst_sys = 1'b0;

    // Single-cycle table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      drive_nop();
      i_mem_wen   = vecs[i].wen;
      i_mem_ren   = vecs[i].ren;
      i_mem_size  = vecs[i].size;
      i_mem_addr  = vecs[i].addr;
      i_mem_wdata = vecs[i].wdata;
      i_result    = vecs[i].result;
      i_rd_wen    = vecs[i].rd_wen;
      i_rd_addr   = vecs[i].rd;
      i_pip_flush = vecs[i].flush;
      i_dbus_gnt  = 1'b1;
      #1;
      check({vecs[i].name, " req"},   o_dbus_req, vecs[i].exp_req);
      check({vecs[i].name, " stall"}, o_stall,    0);
      if (vecs[i].exp_req) begin
        check({vecs[i].name, " we"},    o_dbus_we,    1);
        check({vecs[i].name, " addr"},  o_dbus_addr,  vecs[i].exp_addr);
        check({vecs[i].name, " be"},    o_dbus_be,    vecs[i].exp_be);
        check({vecs[i].name, " wdata"}, o_dbus_wdata, vecs[i].exp_wdata);
      end
      @(posedge clk_sys);
      #1;
      check({vecs[i].name, " rd_wen"},  o_rd_wen,  vecs[i].exp_rd_wen);
      check({vecs[i].name, " rd_addr"}, o_rd_addr, vecs[i].exp_rd);
      check({vecs[i].name, " wb_data"}, o_wb_data, vecs[i].exp_wb);
      drive_nop();
    end

    // Loads: grant at once, rvalid next cycle -> one stall cycle.
    //      name    wen ren size   uns addr     wdata  result rdata         rd gd rd fl st  eaddr    be       ewd   ewb           stl req
    run_mem("LB3",  0, 1, 2'b00, 0, 32'h103, 32'h0, 32'h0, 32'h80FF0000, 7, 0, 0, 0, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1, 1);
    run_mem("LBU3", 0, 1, 2'b00, 1, 32'h103, 32'h0, 32'h0, 32'h80FF0000, 7, 0, 0, 0, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080, 1, 1);
    run_mem("LB0",  0, 1, 2'b00, 0, 32'h100, 32'h0, 32'h0, 32'h1234567F, 8, 0, 0, 0, 0, 32'h100, 4'b0001, 32'h0, 32'h0000007F, 1, 1);
    run_mem("LH2",  0, 1, 2'b01, 0, 32'h102, 32'h0, 32'h0, 32'h80FF0000, 4, 0, 0, 0, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF80FF, 1, 1);
    run_mem("LHU2", 0, 1, 2'b01, 1, 32'h102, 32'h0, 32'h0, 32'h80FF0000, 4, 0, 0, 0, 0, 32'h100, 4'b1100, 32'h0, 32'h000080FF, 1, 1);
    // Delayed grant and rvalid, stray rvalid before grant must be ignored.
    run_mem("LWdly",0, 1, 2'b10, 0, 32'h104, 32'h0, 32'h0, 32'h80FF0000, 3, 2, 1, 0, 1, 32'h104, 4'b1111, 32'h0, 32'h80FF0000, 4, 3);
    // Store with grant delayed 3 cycles: req 4 cycles, 3 stall cycles.
    run_mem("SHdly",1, 0, 2'b01, 0, 32'h102, 32'h1234, 32'h102, 32'h0,   0, 3, 0, 0, 0, 32'h100, 4'b1100, 32'h12341234, 32'h102, 3, 4);
    // Flush held high during RWAIT stall cycles is ignored.
    run_mem("LWfl", 0, 1, 2'b10, 0, 32'h200, 32'h0, 32'h0, 32'hCAFEF00D, 12, 0, 2, 1, 0, 32'h200, 4'b1111, 32'h0, 32'hCAFEF00D, 3, 1);

    // Reset while a load waits for rvalid.
    @(negedge clk_sys);
    i_mem_ren  = 1'b1;
    i_mem_size = 2'b10;
    i_mem_addr = 32'h100;
    i_rd_wen   = 1'b1;
    i_rd_addr  = 5'd10;
    i_dbus_gnt = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    i_dbus_gnt = 1'b0;
    #1;
    check("rwait req", o_dbus_req, 0);
    check("rwait stall", o_stall, 1);
    rst_sys = 1'b1;
    #1;
    check("midrst req",     o_dbus_req, 0);
    check("midrst rd_wen",  o_rd_wen,   0);
    check("midrst rd_addr", o_rd_addr,  0);
    check("midrst wb_data", o_wb_data,  0);
    check("midrst misalign", o_misalign, 0);
    drive_nop();
    #1;
    check("midrst stall", o_stall, 0);
    @(negedge clk_sys);
    rst_sys = 1'b0;
    run_mem("LWpost", 0, 1, 2'b10, 0, 32'h100, 32'h0, 32'h0, 32'h11223344, 9, 0, 0, 0, 0, 32'h100, 4'b1111, 32'h0, 32'h11223344, 1, 1);

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk_sys);
    drive_nop();
    i_mem_ren  = 1'b1;
    i_mem_size = 2'b10;
    i_mem_addr = 32'h101;
    i_rd_wen   = 1'b1;
    i_rd_addr  = 5'd3;
    i_dbus_gnt = 1'b1;
    #1;
    check("mis req",   o_dbus_req, 0);
    check("mis stall", o_stall,    0);
    @(posedge clk_sys);
    #1;
    check("mis pulse",  o_misalign, 1);
    check("mis rd_wen", o_rd_wen,   0);
    drive_nop();
    @(posedge clk_sys);
    #1;
    check("mis pulse end", o_misalign, 0);
`else
    run_mem("LWmis", 0, 1, 2'b10, 0, 32'h101, 32'h0, 32'h0, 32'hA5A51234, 3, 0, 0, 0, 0, 32'h100, 4'b1111, 32'h0, 32'hA5A51234, 1, 1);
    check("nomis misalign", o_misalign, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_macc.md
# lsu_macc

Memory-access stage for the 5-stage RV32I core; consumes the registered EX/MEM outputs of the execute stage (rd/mem controls, address, store data, ALU result) and drives the data bus. Performs aligned byte/half/word loads and stores over a req/gnt/rvalid bus, stalls the pipeline while an access is outstanding, and registers the MEM/WB result that also feeds the WB forwarding path back into execute.

## Interface
- No parameters.
- clk_sys  in  1  system clock, rising edge
- rst_sys  in  1  asynchronous, active-high reset
- i_pip_flush  in  1  clear MEM/WB register (honoured only when o_stall low)
- i_rd_wen / i_rd_addr  in  1 / 5  destination write enable / index from EX
- i_mem_wen / i_mem_ren  in  1 / 1  store / load request from EX (mutually exclusive)
- i_mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- i_mem_unsigned  in  1  zero-extend load (LBU/LHU)
- i_mem_addr / i_mem_wdata / i_result  in  32 each  byte address, store data, ALU result
- o_dbus_req / o_dbus_we  out  1 / 1  bus request / write
- o_dbus_addr  out  32  word address ({addr[31:2],2'b00})
- o_dbus_be  out  4  byte enables
- o_dbus_wdata  out  32  lane-replicated store data
- i_dbus_gnt / i_dbus_rvalid  in  1 / 1  request accepted / read data valid
- i_dbus_rdata  in  32  read data
- o_stall  out  1  hold IF/ID/EX and EX/MEM registers this cycle
- o_misalign  out  1  misaligned-access pulse (see Configuration)
- o_rd_wen / o_rd_addr / o_wb_data  out  1 / 5 / 32  registered MEM/WB; o_wb_data is the WB forwarding source

## Operation
- States: IDLE, REQ (req issued, awaiting gnt), RWAIT (load granted, awaiting rvalid).
- access = i_mem_wen | i_mem_ren, and not misaligned-trapped.
- o_dbus_req = (IDLE & access) | REQ; addr/we/be/wdata driven from inputs, which upstream holds stable while o_stall is high.
- IDLE: access & gnt & store -> stay IDLE (done); access & gnt & load -> RWAIT; access & ~gnt -> REQ.
- REQ: req held until gnt; gnt & store -> IDLE; gnt & load -> RWAIT.
- RWAIT: rvalid -> IDLE. i_dbus_rvalid ignored in IDLE/REQ.
- o_stall = access pending and not completing this cycle: (IDLE & access & ~(store & gnt)) | (REQ & ~(store & gnt)) | (RWAIT & ~rvalid).
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load format: select lane by addr[1:0] from rdata; sign- or zero-extend per i_mem_unsigned; word unchanged.
- MEM/WB register loads when o_stall low: o_rd_wen <= i_rd_wen, o_rd_addr <= i_rd_addr, o_wb_data <= load ? formatted rdata : i_result. Holds while o_stall high.
- i_pip_flush with o_stall low: register loads zeros instead. Flush during a stall is ignored; the in-flight access completes.

## Timing
- Reset: state IDLE; o_rd_wen 0, o_rd_addr 0, o_wb_data 0, o_misalign 0; o_dbus_req 0 immediately (async), o_stall 0 unless inputs request access.
- Store, gnt in first cycle: 0 stall cycles. Each cycle without gnt adds 1 stall cycle.
- Load, gnt in first cycle, rvalid next cycle: 1 stall cycle; data in o_wb_data the edge rvalid is seen.
- Non-memory instruction: 1-cycle pass-through to MEM/WB, no stall.
- Reset mid-access: transaction abandoned, no writeback; bus must tolerate dropped request.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no bus request, no stall, o_misalign registered high for one cycle, o_rd_wen written 0.
- Undefined: o_misalign tied 0; address bits below access size forced to 0 (aligned down) and access proceeds normally.

## Test plan
- SW addr 0x100 data 0xDEADBEEF, gnt same cycle -> req/we 1, be 1111, dbus_addr 0x100, o_stall never high.
- LB addr 0x103, rdata 0x80FF_0000 after gnt+1 -> be 1000, 1 stall cycle, o_wb_data 0xFFFFFF80; LBU -> 0x00000080.
- SH addr 0x102 data 0x1234, gnt delayed 3 cycles -> req held 4 cycles, be 1100, wdata 0x12341234, o_stall 3 cycles.
- ADD result 0x55 rd=5, flush asserted -> o_rd_wen 0, o_wb_data 0; flush during load RWAIT -> ignored, load result written.
- LW addr 0x101: with LSU_MISALIGN_TRAP_EN -> no req, o_misalign 1 cycle, o_rd_wen 0; without -> access at 0x100, be 1111.
- rst_sys pulsed in RWAIT -> req 0, state IDLE, all outputs 0; next LW completes normally.
